// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: one bit per cycle, LSB first.
// The result is published only when the whole word is complete.
module serial_adder #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         ready,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         cout
);

  localparam int KW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [N-1:0]  sa, sb, r;
  logic          c;
  logic [KW-1:0] k;
  logic          s, cy, last;
  logic [N-1:0]  r_nx;

  assign s    = sa[0] ^ sb[0] ^ c;
  assign cy   = (sa[0] & sb[0]) | (c & (sa[0] ^ sb[0]));
  assign r_nx = {s, r[N-1:1]};
  assign last = (k == KW'(N - 1));

  assign ready = (state == IDLE);
  assign done  = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = ADD;
      ADD:     if (last)  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sa   <= '0;
      sb   <= '0;
      r    <= '0;
      c    <= 1'b0;
      k    <= '0;
      sum  <= '0;
      cout <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            sa <= a;
            sb <= b;
            c  <= cin;
            r  <= '0;
            k  <= '0;
          end
        end
        ADD: begin
          r  <= r_nx;
          sa <= sa >> 1;
          sb <= sb >> 1;
          c  <= cy;
          k  <= k + 1'b1;
          // sum/cout only ever see the finished word
          if (last) begin
            sum  <= r_nx;
            cout <= cy;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
